// File: rtl/multi_lane_flag_generator.sv
// Per-lane DDR training data-quality monitor: sticky noise/transition flags,
// saturating per-lane noise counters and a settle phase before monitoring.
module multi_lane_flag_generator #(
    parameter int NUM_LANES     = 8,
    parameter int DATA_WIDTH    = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data,
    input  logic                            enable,
    input  logic                            sample,
    input  logic                            clear_flags,
    output logic [NUM_LANES-1:0]            lane_noise_flag,
    output logic [NUM_LANES-1:0]            lane_transition_flag,
    output logic [NUM_LANES-1:0]            lane_flag,
    output logic                            any_flag,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  noise_count,
    output logic                            settled,
    output logic [1:0]                      state
);

    // state   | meaning
    // IDLE    | monitor off, waiting for enable
    // SETTLE  | waiting for STABLE_CYCLES consecutive all-lane-stable cycles
    // MONITOR | noise detection and sample capture active
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MONITOR = 2'd2
    } state_t;

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                                    state_q, state_d;
    logic [SCW-1:0]                            stab_q, stab_d;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      data0_q, data1_q;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      snap0_q, snap0_d, snap1_q, snap1_d;
    logic [NUM_LANES-1:0][CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [NUM_LANES-1:0]                      noise_q, noise_d, trans_q, trans_d;
    logic [1:0]                                vcnt_q, vcnt_d;
    logic                                      sample_q;
    logic [NUM_LANES-1:0]                      unstable;
    logic                                      capture;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            unstable[i] = |(data0_q[i] ^ data1_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SETTLE;
                    stab_d  = '0;
                end
            end
            SETTLE: begin
                if (|unstable) begin
                    stab_d = '0;
                end else if (stab_q == SCW'(STABLE_CYCLES)) begin
                    state_d = MONITOR;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            MONITOR: ;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            stab_d  = '0;
        end
    end

    assign capture = sample && !sample_q && (state_q == MONITOR);

    always_comb begin
        noise_d = noise_q;
        cnt_d   = cnt_q;
        trans_d = trans_q;
        snap0_d = snap0_q;
        snap1_d = snap1_q;
        vcnt_d  = vcnt_q;
        if (state_q == MONITOR) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (unstable[i]) begin
                    noise_d[i] = 1'b1;
                    if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        if (capture) begin
            snap1_d = snap0_q;
            snap0_d = data1_q;
            if (vcnt_q != 2'd2) vcnt_d = vcnt_q + 2'd1;
        end
        if (vcnt_q == 2'd2) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (snap0_q[i] != snap1_q[i]) trans_d[i] = 1'b1;
            end
        end
        if (!enable) vcnt_d = '0;
        // clear takes priority over any same-cycle set or increment
        if (clear_flags) begin
            noise_d = '0;
            cnt_d   = '0;
            trans_d = '0;
            snap0_d = '0;
            snap1_d = '0;
            vcnt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            stab_q   <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
            snap0_q  <= '0;
            snap1_q  <= '0;
            cnt_q    <= '0;
            noise_q  <= '0;
            trans_q  <= '0;
            vcnt_q   <= '0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stab_q   <= stab_d;
            data0_q  <= data;
            data1_q  <= data0_q;
            snap0_q  <= snap0_d;
            snap1_q  <= snap1_d;
            cnt_q    <= cnt_d;
            noise_q  <= noise_d;
            trans_q  <= trans_d;
            vcnt_q   <= vcnt_d;
            sample_q <= sample;
        end
    end

    assign lane_noise_flag      = noise_q;
    assign lane_transition_flag = trans_q;
    assign lane_flag            = noise_q | trans_q;
    assign any_flag             = |lane_flag;
    assign noise_count          = cnt_q;
    assign settled              = (state_q == MONITOR);
    assign state                = state_q;

endmodule

// File: tb/tb_multi_lane_flag_generator.sv
// Directed bench for multi_lane_flag_generator with default parameters.
module tb_multi_lane_flag_generator;

    logic        clock;
    logic        reset_n;
    logic [15:0] data;
    logic        enable;
    logic        sample;
    logic        clear_flags;
    logic [7:0]  lane_noise_flag;
    logic [7:0]  lane_transition_flag;
    logic [7:0]  lane_flag;
    logic        any_flag;
    logic [63:0] noise_count;
    logic        settled;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    multi_lane_flag_generator dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .data                 (data),
        .enable               (enable),
        .sample               (sample),
        .clear_flags          (clear_flags),
        .lane_noise_flag      (lane_noise_flag),
        .lane_transition_flag (lane_transition_flag),
        .lane_flag            (lane_flag),
        .any_flag             (any_flag),
        .noise_count          (noise_count),
        .settled              (settled),
        .state                (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_sample();
        sample = 1'b1;
        tick(1);
        sample = 1'b0;
        tick(3);
    endtask

    initial begin
        reset_n     = 1'b0;
        data        = 16'h0000;
        enable      = 1'b0;
        sample      = 1'b0;
        clear_flags = 1'b0;
        tick(2);
        chk("reset_state", state, 2'd0);
        chk("reset_settled", settled, 1'b0);
        chk("reset_any", any_flag, 1'b0);
        chk("reset_noise_flag", lane_noise_flag, 8'h00);
        chk("reset_trans_flag", lane_transition_flag, 8'h00);
        chk("reset_count", noise_count, 64'h0);

        // 1: settle with constant data
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(1);
        chk("t1_settle_entry", state, 2'd1);
        tick(4);
        chk("t1_not_yet_settled", settled, 1'b0);
        tick(1);
        chk("t1_settled", settled, 1'b1);
        chk("t1_state_monitor", state, 2'd2);
        chk("t1_no_flags", lane_flag, 8'h00);

        // 2: lane 3 toggling holds SETTLE
        enable = 1'b0;
        tick(1);
        chk("t2_idle", state, 2'd0);
        enable = 1'b1;
        tick(1);
        for (int j = 0; j < 15; j++) begin
            if (j % 3 == 0) data = data ^ 16'h0040;
            tick(1);
        end
        chk("t2_stays_settle", state, 2'd1);
        for (int j = 0; j < 20; j++) begin
            if (state == 2'd2) break;
            tick(1);
        end
        chk("t2_reaches_monitor", state, 2'd2);
        chk("t2_no_noise_in_settle", noise_count, 64'h0);

        // 3: single-cycle glitch on lane 5
        data = data | 16'h0C00;
        tick(1);
        data = data & ~16'h0C00;
        tick(2);
        chk("t3_noise_flag", lane_noise_flag, 8'h20);
        chk("t3_count5", noise_count[47:40], 8'd2);
        chk("t3_any_flag", any_flag, 1'b1);
        chk("t3_lane_flag", lane_flag, 8'h20);
        tick(2);
        chk("t3_count5_holds", noise_count[47:40], 8'd2);

        // 4: saturation on lane 0, clear wins over same-cycle glitch
        for (int j = 0; j < 300; j++) begin
            data[0] = ~data[0];
            tick(1);
        end
        chk("t4_saturate", noise_count[7:0], 8'd255);
        chk("t4_noise_flag", lane_noise_flag, 8'h21);
        data[0]     = ~data[0];
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("t4_clear_count0", noise_count[7:0], 8'd0);
        chk("t4_clear_all", noise_count, 64'h0);
        chk("t4_clear_flags", lane_noise_flag, 8'h00);
        tick(3);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        tick(2);
        chk("t4_quiet_after_clear", noise_count, 64'h0);
        chk("t4_state_kept", state, 2'd2);

        // 5: transition flag only after third capture
        data[5:4] = 2'b01;
        tick(3);
        pulse_sample();
        pulse_sample();
        chk("t5_no_trans_yet", lane_transition_flag, 8'h00);
        data[5:4] = 2'b10;
        tick(3);
        pulse_sample();
        chk("t5_trans_lane2", lane_transition_flag, 8'h04);

        // held sample produces one capture only
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        tick(2);
        sample = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j == 5) data[5:4] = 2'b01;
            tick(1);
        end
        sample = 1'b0;
        tick(3);
        chk("t5_held_no_trans", lane_transition_flag, 8'h00);
        pulse_sample();
        chk("t5_held_single_capture", lane_transition_flag, 8'h04);

        // 6: enable drop keeps flags, async reset clears everything
        enable = 1'b0;
        tick(1);
        chk("t6_idle", state, 2'd0);
        chk("t6_settled_low", settled, 1'b0);
        tick(2);
        chk("t6_trans_kept", lane_transition_flag, 8'h04);
        chk("t6_any_kept", any_flag, 1'b1);
        enable = 1'b1;
        tick(2);
        chk("t6_settle", state, 2'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_state", state, 2'd0);
        chk("t6_rst_noise", lane_noise_flag, 8'h00);
        chk("t6_rst_trans", lane_transition_flag, 8'h00);
        chk("t6_rst_any", any_flag, 1'b0);
        chk("t6_rst_count", noise_count, 64'h0);
        chk("t6_rst_settled", settled, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
